// File: rtl/iir_sos_cascade.sv
// Cascade of NUM_SOS Direct Form I biquads sharing a single multiply-accumulator.
// Define IIR_SAT_CNT_EN to add the sat_count port (section saturation event counter).
module iir_sos_cascade #(
    parameter int NUM_SOS   = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipeline_en,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              coef_wr_en,
    input  logic [7:0]        coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    output logic              busy,
    output logic              sos_out_valid,
    output logic [DATA_W-1:0] sos_out_data,
    output logic              overflow,
    output logic              sample_drop
`ifdef IIR_SAT_CNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam int NUM_COEF = NUM_SOS * 5;
    localparam int SEC_W    = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;
    localparam int CIDX_W   = $clog2(NUM_COEF);
    localparam int PROD_W   = DATA_W + COEF_W;

    localparam logic [SEC_W-1:0]         LAST_SEC   = SEC_W'(NUM_SOS - 1);
    localparam logic [7:0]               COEF_LIMIT = 8'(NUM_COEF);
    localparam logic signed [COEF_W-1:0] COEF_ONE   =
        {{(COEF_W-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};
    localparam logic signed [ACC_W-1:0]  RND        =
        {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  Y_MAX      =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  Y_MIN      =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_t;

    state_t                   state, state_nx;
    logic [2:0]               slot;
    logic [SEC_W-1:0]         section;
    logic                     accept, mac_en, fin_en, out_en;

    logic signed [COEF_W-1:0] coef [NUM_COEF];
    logic signed [DATA_W-1:0] x1 [NUM_SOS];
    logic signed [DATA_W-1:0] x2 [NUM_SOS];
    logic signed [DATA_W-1:0] y1 [NUM_SOS];
    logic signed [DATA_W-1:0] y2 [NUM_SOS];
    logic signed [DATA_W-1:0] x_cur;
    logic signed [ACC_W-1:0]  acc;

    logic [CIDX_W-1:0]        rd_idx;
    logic signed [DATA_W-1:0] mac_d;
    logic signed [COEF_W-1:0] mac_c;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, acc_rnd, y_full;
    logic signed [DATA_W-1:0] y_sat;
    logic                     clip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!pipeline_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (data_in_valid) state_nx = MAC;
                MAC:     if (slot == 3'd4) state_nx = FINAL;
                FINAL:   state_nx = (section == LAST_SEC) ? OUT : MAC;
                OUT:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = pipeline_en && data_in_valid && (state == IDLE);
        mac_en = pipeline_en && (state == MAC);
        fin_en = pipeline_en && (state == FINAL);
        out_en = pipeline_en && (state == OUT);
    end

    // Slot wraps after the fifth product so FINAL always sees slot 0 and in-range reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= '0;
            section <= '0;
        end else if (accept) begin
            slot    <= '0;
            section <= '0;
        end else if (mac_en) begin
            slot <= (slot == 3'd4) ? '0 : slot + 3'd1;
        end else if (fin_en) begin
            section <= (section == LAST_SEC) ? '0 : section + SEC_W'(1);
        end
    end

    always_comb begin
        rd_idx = CIDX_W'(32'(section) * 32'd5 + 32'(slot));
        mac_c  = coef[rd_idx];
        case (slot)
            3'd0:    mac_d = x_cur;
            3'd1:    mac_d = x1[section];
            3'd2:    mac_d = x2[section];
            3'd3:    mac_d = y1[section];
            default: mac_d = y2[section];
        endcase
        prod     = PROD_W'(mac_d) * PROD_W'(mac_c);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_rnd  = acc + RND;
        y_full   = acc_rnd >>> COEF_FRAC;
        clip     = 1'b0;
        y_sat    = y_full[DATA_W-1:0];
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[DATA_W-1:0];
            clip  = 1'b1;
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[DATA_W-1:0];
            clip  = 1'b1;
        end
    end

    // Feedback products (a1, a2) are subtracted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (mac_en) begin
            if (slot == 3'd0)      acc <= prod_ext;
            else if (slot >= 3'd3) acc <= acc - prod_ext;
            else                   acc <= acc + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1    <= '{default: '0};
            x2    <= '{default: '0};
            y1    <= '{default: '0};
            y2    <= '{default: '0};
            x_cur <= '0;
        end else if (!pipeline_en) begin
            x1 <= '{default: '0};
            x2 <= '{default: '0};
            y1 <= '{default: '0};
            y2 <= '{default: '0};
        end else begin
            if (accept) x_cur <= data_in;
            if (fin_en) begin
                x2[section] <= x1[section];
                x1[section] <= x_cur;
                y2[section] <= y1[section];
                y1[section] <= y_sat;
                x_cur       <= y_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_COEF; i++)
                coef[CIDX_W'(i)] <= (i % 5 == 0) ? COEF_ONE : '0;
        end else if (coef_wr_en && !busy && (coef_wr_addr < COEF_LIMIT)) begin
            coef[coef_wr_addr[CIDX_W-1:0]] <= coef_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sos_out_valid <= 1'b0;
            sos_out_data  <= '0;
            overflow      <= 1'b0;
            sample_drop   <= 1'b0;
        end else begin
            sos_out_valid <= out_en;
            if (out_en) sos_out_data <= x_cur;
            if (!pipeline_en) begin
                overflow    <= 1'b0;
                sample_drop <= 1'b0;
            end else begin
                if (fin_en && clip)        overflow    <= 1'b1;
                if (data_in_valid && busy) sample_drop <= 1'b1;
            end
        end
    end

`ifdef IIR_SAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         sat_count <= '0;
        else if (!pipeline_en)                           sat_count <= '0;
        else if (fin_en && clip && (sat_count != '1))    sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Self-checking bench for iir_sos_cascade: directed vector table, corner sequences,
// and randomized samples against a per-section arithmetic reference model.
module tb_iir_sos_cascade;

    localparam int NUM_SOS   = 4;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int ACC_W     = 40;
    localparam int NCOEF     = NUM_SOS * 5;
    localparam int LAT       = 6 * NUM_SOS + 1;
    localparam longint ONE   = longint'(1) << COEF_FRAC;
    localparam longint HALF  = longint'(1) << (COEF_FRAC - 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              pipeline_en;
    logic              data_in_valid;
    logic [DATA_W-1:0] data_in;
    logic              coef_wr_en;
    logic [7:0]        coef_wr_addr;
    logic [COEF_W-1:0] coef_wr_data;
    logic              busy;
    logic              sos_out_valid;
    logic [DATA_W-1:0] sos_out_data;
    logic              overflow;
    logic              sample_drop;
`ifdef IIR_SAT_CNT_EN
    logic [15:0]       sat_count;
`endif

    iir_sos_cascade #(
        .NUM_SOS   (NUM_SOS),
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipeline_en   (pipeline_en),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .busy          (busy),
        .sos_out_valid (sos_out_valid),
        .sos_out_data  (sos_out_data),
        .overflow      (overflow),
        .sample_drop   (sample_drop)
`ifdef IIR_SAT_CNT_EN
        ,
        .sat_count     (sat_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: coefficients and per-section DF-I history
    int     mcoef [NCOEF];
    longint mx1 [NUM_SOS];
    longint mx2 [NUM_SOS];
    longint my1 [NUM_SOS];
    longint my2 [NUM_SOS];
    bit     m_ovf;

    typedef struct {
        bit clr;
        int b0, b1, b2, a1, a2;
        int x;
        int y;
        bit ovf;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset_coefs();
        for (int i = 0; i < NCOEF; i++) mcoef[i] = (i % 5 == 0) ? int'(ONE) : 0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < NUM_SOS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input longint x_in, output longint y);
        longint x, acc;
        x = x_in;
        y = 0;
        for (int s = 0; s < NUM_SOS; s++) begin
            acc = mcoef[s*5] * x + mcoef[s*5+1] * mx1[s] + mcoef[s*5+2] * mx2[s]
                - mcoef[s*5+3] * my1[s] - mcoef[s*5+4] * my2[s];
            y = (acc + HALF) >>> COEF_FRAC;
            if (y > 32767)       begin y = 32767;  m_ovf = 1'b1; end
            else if (y < -32768) begin y = -32768; m_ovf = 1'b1; end
            mx2[s] = mx1[s]; mx1[s] = x;
            my2[s] = my1[s]; my1[s] = y;
            x = y;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 8'(addr);
        coef_wr_data = COEF_W'(data);
        tick();
        coef_wr_en   = 1'b0;
        if (addr < NCOEF) mcoef[addr] = data;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_reset_coefs();
        model_clear();
    endtask

    task automatic pipe_off();
        pipeline_en = 1'b0;
        tick();
        pipeline_en = 1'b1;
        model_clear();
    endtask

    // Presents one sample; optional coef write on the accepting edge and an
    // extra strobe drop_at edges after acceptance.
    task automatic send_sample(input int x, input int drop_at, input bit wr,
                               input int waddr, input int wdata,
                               output int y, output int lat, output bit busy_ok);
        data_in       = DATA_W'(x);
        data_in_valid = 1'b1;
        if (wr) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 8'(waddr);
            coef_wr_data = COEF_W'(wdata);
        end
        tick();
        data_in_valid = 1'b0;
        coef_wr_en    = 1'b0;
        lat = 0; y = 0; busy_ok = 1'b1;
        for (int i = 1; i <= LAT + 20; i++) begin
            if (i == drop_at) begin
                data_in       = 16'h1234;
                data_in_valid = 1'b1;
            end
            tick();
            data_in_valid = 1'b0;
            if (sos_out_valid) begin
                lat = i;
                y   = int'($signed(sos_out_data));
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string tag, input int x, input int exp_y, input int drop_at,
                             input bit wr, input int waddr, input int wdata);
        int y, lat;
        bit bok;
        send_sample(x, drop_at, wr, waddr, wdata, y, lat, bok);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_y"}, y, exp_y);
        check({tag, "_busy"}, bok, 1);
        check({tag, "_idle"}, busy, 0);
        tick();
        check({tag, "_pulse"}, sos_out_valid, 0);
    endtask

    task automatic count_outputs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (sos_out_valid) n++;
        end
    endtask

    initial begin
        int     y, lat, n;
        bit     bok;
        longint my;
        int     x;

        vt[0] = '{1'b1, 16384, 0,    0, 0,     0, 1000,  1000,  1'b0};
        vt[1] = '{1'b1, 8192,  8192, 0, 0,     0, 1000,  500,   1'b0};
        vt[2] = '{1'b0, 8192,  8192, 0, 0,     0, 2000,  1500,  1'b0};
        vt[3] = '{1'b1, 16384, 0,    0, -8192, 0, 16384, 16384, 1'b0};
        vt[4] = '{1'b0, 16384, 0,    0, -8192, 0, 0,     8192,  1'b0};
        vt[5] = '{1'b0, 16384, 0,    0, -8192, 0, 0,     4096,  1'b0};
        vt[6] = '{1'b1, 8192,  0,    0, 0,     0, 3,     2,     1'b0};
        vt[7] = '{1'b1, 8192,  0,    0, 0,     0, -3,    -1,    1'b0};

        rst = 1'b1; pipeline_en = 1'b0; data_in_valid = 1'b0; data_in = '0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        model_reset_coefs();
        model_clear();
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_valid", sos_out_valid, 0);
        check("rst_data", sos_out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", sample_drop, 0);
        rst = 1'b0; pipeline_en = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vt[i].clr) pipe_off();
            write_coef(0, vt[i].b0); write_coef(1, vt[i].b1); write_coef(2, vt[i].b2);
            write_coef(3, vt[i].a1); write_coef(4, vt[i].a2);
            run_check($sformatf("vec%0d", i), vt[i].x, vt[i].y, 0, 1'b0, 0, 0);
            check($sformatf("vec%0d_ovf", i), overflow, vt[i].ovf);
        end

        // Saturation in every section, then clear via pipeline_en
        do_rst();
        for (int s = 0; s < NUM_SOS; s++) write_coef(s * 5, 32767);
        run_check("sat_pos", 20000, 32767, 0, 1'b0, 0, 0);
        check("sat_pos_ovf", overflow, 1);
        run_check("sat_neg", -20000, -32768, 0, 1'b0, 0, 0);
        check("sat_neg_ovf", overflow, 1);
        pipeline_en = 1'b0;
        tick();
        check("sat_clr_ovf", overflow, 0);
        pipeline_en = 1'b1;

        // Strobe while computing is dropped
        do_rst();
        run_check("drop5", 1000, 1000, 5, 1'b0, 0, 0);
        check("drop5_flag", sample_drop, 1);
        count_outputs(40, n);
        check("drop5_extra", n, 0);

        // Strobe in the OUT cycle is dropped
        pipe_off();
        check("drop_clr", sample_drop, 0);
        run_check("drop_out", 500, 500, LAT, 1'b0, 0, 0);
        check("drop_out_flag", sample_drop, 1);
        count_outputs(40, n);
        check("drop_out_extra", n, 0);

        // Strobe in IDLE right after OUT is accepted
        pipe_off();
        send_sample(111, 0, 1'b0, 0, 0, y, lat, bok);
        check("b2b_first_y", y, 111);
        send_sample(222, 0, 1'b0, 0, 0, y, lat, bok);
        check("b2b_second_lat", lat, LAT);
        check("b2b_second_y", y, 222);
        check("b2b_drop", sample_drop, 0);
        tick();

        // Coefficient write on the accepting edge is used by that sample
        run_check("wr_accept", 1000, 500, 0, 1'b1, 0, 8192);

        // Coefficient write while busy is ignored
        data_in = 16'd1000; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick(); tick();
        coef_wr_en = 1'b1; coef_wr_addr = 8'd0; coef_wr_data = '0;
        tick();
        coef_wr_en = 1'b0;
        y = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            tick();
            if (sos_out_valid) begin
                y = int'($signed(sos_out_data));
                break;
            end
        end
        check("busy_wr_y", y, 500);
        tick();

        // Reset mid-computation aborts and restores passthrough coefficients
        data_in = 16'd1000; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_outputs(40, n);
        check("rst_mid_outputs", n, 0);
        check("rst_mid_busy", busy, 0);
        model_reset_coefs();
        model_clear();
        run_check("rst_mid_pass", 1234, 1234, 0, 1'b0, 0, 0);

        // Randomized coefficients and samples against the reference model
        do_rst();
        for (int a = 0; a < NCOEF; a++) begin
            if (a % 5 < 3) write_coef(a, int'($urandom_range(0, 32767)) - 16384);
            else           write_coef(a, int'($urandom_range(0, 16383)) - 8192);
        end
        for (int k = 0; k < 40; k++) begin
            if (k % 13 == 12) pipe_off();
            x = int'($urandom_range(0, 65535)) - 32768;
            model_step(longint'(x), my);
            run_check($sformatf("rnd%0d", k), x, int'(my), 0, 1'b0, 0, 0);
            check($sformatf("rnd%0d_ovf", k), overflow, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
